// File: rtl/tmds_pll_supervisor_pkg.sv
// TMDS PLL supervisor shared types.
// State encoding, count width and small helpers.
package tmds_pll_pkg;

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    RELEASE_SER,
    RUN
  } pll_state_e;

  localparam int COUNT_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(
    input logic [COUNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tmds_pll_supervisor_sync_2ff.sv
// Single-bit two-flop synchroniser.
// Async active-low reset clears both flops.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tmds_pll_supervisor.sv
// TMDS rPLL bring-up sequencer on the 27 MHz reference clock.
// Pulses PLL reset, qualifies lock, releases ser then pix resets.
module tmds_pll_supervisor
  import tmds_pll_pkg::*;
#(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_GAP_CYCLES  = 8,
  parameter int MAX_RETRIES         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               restart_req,
  output logic               pll_reset,
  output logic               ser_rst_n,
  output logic               pix_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [COUNT_W-1:0] relock_count,
  output logic [COUNT_W-1:0] timeout_count
);

  localparam int MAXP = max2(
    max2(RESET_CYCLES, LOCK_STABLE_CYCLES),
    max2(LOCK_TIMEOUT_CYCLES,
         max2(RELEASE_GAP_CYCLES, MAX_RETRIES)));
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RELEASE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] MAXR     = CW'(MAX_RETRIES);

  pll_state_e         state_q, state_d;
  logic [CW-1:0]      cyc_q, cyc_d;
  logic [CW-1:0]      stab_q, stab_d;
  logic [CW-1:0]      consec_q, consec_d;
  logic [COUNT_W-1:0] relock_q, relock_d;
  logic [COUNT_W-1:0] tmo_q, tmo_d;
  logic               fault_q, fault_d;
  logic               go_reset;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stab_d   = stab_q;
    consec_d = consec_q;
    relock_d = relock_q;
    tmo_d    = tmo_q;
    fault_d  = fault_q;
    go_reset = 1'b0;
    unique case (state_q)
      RESET_PLL: begin
        if (restart_req) begin
          cyc_d = '0;
        end else if (cyc_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cyc_d   = '0;
          stab_d  = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (restart_req) begin
          go_reset = 1'b1;
        end else if (lock_s && stab_q == STB_LAST) begin
          // stable lock beats a timeout landing on the same edge
          state_d  = RELEASE_SER;
          cyc_d    = '0;
          consec_d = '0;
        end else if (cyc_q == TMO_LAST) begin
          go_reset = 1'b1;
          tmo_d    = sat_inc(tmo_q);
          if (consec_q != '1) consec_d = consec_q + 1'b1;
          if (consec_d >= MAXR) fault_d = 1'b1;
        end else begin
          cyc_d  = cyc_q + 1'b1;
          stab_d = lock_s ? stab_q + 1'b1 : '0;
        end
      end
      RELEASE_SER: begin
        if (restart_req || !lock_s) begin
          go_reset = 1'b1;
        end else if (cyc_q == GAP_LAST) begin
          state_d = RUN;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) relock_d = sat_inc(relock_q);
        if (!lock_s || restart_req) go_reset = 1'b1;
      end
      default: go_reset = 1'b1;
    endcase
    if (go_reset) begin
      state_d = RESET_PLL;
      cyc_d   = '0;
      stab_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_PLL;
      cyc_q     <= '0;
      stab_q    <= '0;
      consec_q  <= '0;
      relock_q  <= '0;
      tmo_q     <= '0;
      fault_q   <= 1'b0;
      pll_reset <= 1'b1;
      ser_rst_n <= 1'b0;
      pix_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stab_q    <= stab_d;
      consec_q  <= consec_d;
      relock_q  <= relock_d;
      tmo_q     <= tmo_d;
      fault_q   <= fault_d;
      pll_reset <= (state_d == RESET_PLL);
      ser_rst_n <= (state_d == RELEASE_SER) || (state_d == RUN);
      pix_rst_n <= (state_d == RUN);
      ready     <= (state_d == RUN);
    end
  end

  assign fault         = fault_q;
  assign relock_count  = relock_q;
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_tmds_pll_supervisor.sv
// Bench for tmds_pll_supervisor.
// Timeline expectations queued per cycle, checked at negedge.
module tb_tmds_pll_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       restart_req;
  logic       pll_reset;
  logic       ser_rst_n;
  logic       pix_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  tmds_pll_supervisor #(
    .RESET_CYCLES        (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .RELEASE_GAP_CYCLES  (2),
    .MAX_RETRIES         (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .restart_req   (restart_req),
    .pll_reset     (pll_reset),
    .ser_rst_n     (ser_rst_n),
    .pix_rst_n     (pix_rst_n),
    .ready         (ready),
    .fault         (fault),
    .relock_count  (relock_count),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          abs_c;
    logic [20:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tcyc = 0;
  int   base = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [20:0] snap;
  assign snap = {pll_reset, ser_rst_n, pix_rst_n, ready, fault,
                 relock_count, timeout_count};

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [20:0] mk(bit pr, bit ser, bit pix,
                                     bit rdy, bit flt,
                                     int rel, int tmo);
    return {pr, ser, pix, rdy, flt, 8'(rel), 8'(tmo)};
  endfunction

  task automatic exp_at(int c, string tag, logic [20:0] v);
    exp_t x;
    x.abs_c = base + c;
    x.v     = v;
    x.tag   = tag;
    sb.push_back(x);
  endtask

  // move to #1 after the edge that starts cycle c
  task automatic go(int c);
    while (tcyc < base + c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(bit lock);
    rst_n       = 1'b0;
    pll_lock    = lock;
    restart_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = tcyc;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].abs_c <= tcyc) begin
      e = sb.pop_front();
      chk(e.tag, {11'd0, snap}, {11'd0, e.v});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    pll_lock    = 1'b1;
    restart_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {11'd0, snap}, {11'd0, mk(1, 0, 0, 0, 0, 0, 0)});

    // power-up with lock present
    do_reset(1'b1);
    exp_at(0,  "s1_c0",   mk(1, 0, 0, 0, 0, 0, 0));
    exp_at(3,  "s1_c3",   mk(1, 0, 0, 0, 0, 0, 0));
    exp_at(4,  "s1_c4",   mk(0, 0, 0, 0, 0, 0, 0));
    exp_at(11, "s1_c11",  mk(0, 0, 0, 0, 0, 0, 0));
    exp_at(12, "s1_ser",  mk(0, 1, 0, 0, 0, 0, 0));
    exp_at(13, "s1_gap",  mk(0, 1, 0, 0, 0, 0, 0));
    exp_at(14, "s1_run",  mk(0, 1, 1, 1, 0, 0, 0));
    exp_at(20, "s1_hold", mk(0, 1, 1, 1, 0, 0, 0));
    go(21);
    chk("s1_drain", sb.size(), 0);

    // lock glitch in WAIT_LOCK, then lock loss in RUN
    do_reset(1'b1);
    exp_at(9,  "s2_glitch", mk(0, 0, 0, 0, 0, 0, 0));
    exp_at(10, "s2_after",  mk(0, 0, 0, 0, 0, 0, 0));
    exp_at(17, "s2_hold",   mk(0, 0, 0, 0, 0, 0, 0));
    exp_at(18, "s2_ser",    mk(0, 1, 0, 0, 0, 0, 0));
    exp_at(20, "s2_run",    mk(0, 1, 1, 1, 0, 0, 0));
    exp_at(26, "s3_pre",    mk(0, 1, 1, 1, 0, 0, 0));
    exp_at(27, "s3_loss",   mk(1, 0, 0, 0, 0, 1, 0));
    exp_at(30, "s3_rst",    mk(1, 0, 0, 0, 0, 1, 0));
    exp_at(31, "s3_wait",   mk(0, 0, 0, 0, 0, 1, 0));
    exp_at(38, "s3_hold",   mk(0, 0, 0, 0, 0, 1, 0));
    exp_at(39, "s3_ser",    mk(0, 1, 0, 0, 0, 1, 0));
    exp_at(40, "s3_gap",    mk(0, 1, 0, 0, 0, 1, 0));
    exp_at(41, "s3_run",    mk(0, 1, 1, 1, 0, 1, 0));
    go(7);
    pll_lock = 1'b0;
    go(8);
    pll_lock = 1'b1;
    go(24);
    pll_lock = 1'b0;
    go(28);
    pll_lock = 1'b1;
    go(42);
    chk("s23_drain", sb.size(), 0);

    // timeouts, fault, restart handling, async reset
    do_reset(1'b0);
    exp_at(0,   "s4_c0",    mk(1, 0, 0, 0, 0, 0, 0));
    exp_at(3,   "s4_c3",    mk(1, 0, 0, 0, 0, 0, 0));
    exp_at(4,   "s4_wait",  mk(0, 0, 0, 0, 0, 0, 0));
    exp_at(35,  "s4_pre1",  mk(0, 0, 0, 0, 0, 0, 0));
    exp_at(36,  "s4_tmo1",  mk(1, 0, 0, 0, 0, 0, 1));
    exp_at(39,  "s4_pls1",  mk(1, 0, 0, 0, 0, 0, 1));
    exp_at(40,  "s4_wait2", mk(0, 0, 0, 0, 0, 0, 1));
    exp_at(71,  "s4_pre2",  mk(0, 0, 0, 0, 0, 0, 1));
    exp_at(72,  "s4_tmo2",  mk(1, 0, 0, 0, 1, 0, 2));
    exp_at(76,  "s4_wait3", mk(0, 0, 0, 0, 1, 0, 2));
    exp_at(84,  "s4_ser",   mk(0, 1, 0, 0, 1, 0, 2));
    exp_at(86,  "s4_run",   mk(0, 1, 1, 1, 1, 0, 2));
    exp_at(90,  "s5_pre",   mk(0, 1, 1, 1, 1, 0, 2));
    exp_at(91,  "s5_both",  mk(1, 0, 0, 0, 1, 1, 2));
    exp_at(95,  "s5_wait",  mk(0, 0, 0, 0, 1, 1, 2));
    exp_at(103, "s5_ser",   mk(0, 1, 0, 0, 1, 1, 2));
    exp_at(105, "s5_run",   mk(0, 1, 1, 1, 1, 1, 2));
    exp_at(110, "s5_pre2",  mk(0, 1, 1, 1, 1, 1, 2));
    exp_at(111, "s5_rreq",  mk(1, 0, 0, 0, 1, 1, 2));
    exp_at(115, "s5_wait2", mk(0, 0, 0, 0, 1, 1, 2));
    exp_at(125, "s5_run2",  mk(0, 1, 1, 1, 1, 1, 2));
    exp_at(143, "s6_ser",   mk(0, 1, 0, 0, 1, 1, 2));
    go(72);
    pll_lock = 1'b1;
    go(88);
    pll_lock = 1'b0;
    go(90);
    restart_req = 1'b1;
    go(91);
    restart_req = 1'b0;
    pll_lock    = 1'b1;
    go(110);
    restart_req = 1'b1;
    go(111);
    restart_req = 1'b0;
    go(130);
    restart_req = 1'b1;
    go(131);
    restart_req = 1'b0;
    go(144);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_async", {11'd0, snap}, {11'd0, mk(1, 0, 0, 0, 0, 0, 0)});
    chk("s6_drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("s6_held", {11'd0, snap}, {11'd0, mk(1, 0, 0, 0, 0, 0, 0)});
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tmds_pll_supervisor.md
Name: tmds_pll_supervisor

Overview:
Sequences the TMDS clock PLL (rPLL: serial clock on CLKOUT, pixel clock on CLKOUTD) from reset to a stable running state.
- Pulses the PLL reset and qualifies LOCK with a stability window.
- Releases the serializer reset, then the pixel-domain reset, in order.
- Detects lock loss or lock timeout, re-runs the sequence, and keeps health counters.
- Runs on the free-running 27 MHz board clock, the PLL input clock. All outputs are in that domain; consumers in the PLL clock domains resynchronise them.

Parameters:
RESET_CYCLES, 16, width of each PLL reset pulse in clk cycles (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock-high cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before retrying the PLL reset (> LOCK_STABLE_CYCLES)
RELEASE_GAP_CYCLES, 8, cycles between ser_rst_n release and pix_rst_n release (>=1)
MAX_RETRIES, 4, consecutive timeouts that set the sticky fault flag (>=1)

Ports:
clk  in  1  27 MHz reference clock, also the PLL CLKIN
rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL LOCK, asynchronous to clk
restart_req  in  1  single-cycle request to re-run the full sequence
pll_reset  out  1  drives PLL RESET, active high
ser_rst_n  out  1  serializer (TMDS 5x domain) reset, active low
pix_rst_n  out  1  pixel-domain reset, active low
ready  out  1  high only in RUN
fault  out  1  sticky: MAX_RETRIES consecutive lock timeouts occurred
relock_count  out  8  saturating count of lock losses in RUN
timeout_count  out  8  saturating count of WAIT_LOCK timeouts

Behaviour:
- Reset: asynchronous and active-low.
  - While rst_n is low: pll_reset=1, ser_rst_n=0, pix_rst_n=0, ready=0, fault=0, both counts 0, state RESET_PLL, all counters 0.
- Lock synchroniser: pll_lock passes through a 2-flop synchroniser to give lock_s. Lock decisions therefore lag the pin by 2 cycles.
- States:
  - RESET_PLL: pll_reset=1. After RESET_CYCLES cycles in this state, go to WAIT_LOCK and clear the cycle counter.
  - WAIT_LOCK: pll_reset=0.
    - The stable counter increments while lock_s=1 and clears when lock_s=0.
    - When the stable counter reaches LOCK_STABLE_CYCLES, go to RELEASE_SER and clear the consecutive-timeout counter.
    - When the timeout counter reaches LOCK_TIMEOUT_CYCLES, go to RESET_PLL, increment timeout_count and the consecutive-timeout counter, and set fault when the consecutive count reaches MAX_RETRIES.
    - If stable and timeout complete in the same cycle, stable wins.
  - RELEASE_SER: ser_rst_n=1, pix_rst_n=0. After RELEASE_GAP_CYCLES cycles, go to RUN.
  - RUN: ser_rst_n=1, pix_rst_n=1, ready=1.
- Output timing: outputs are registered and change on the clock edge that enters the state.
- Lock loss: lock_s=0 in RELEASE_SER or RUN causes the following on the next edge:
  - ser_rst_n=0, pix_rst_n=0, ready=0, pll_reset=1, state RESET_PLL.
  - relock_count increments only if the loss happened in RUN.
- restart_req in any state other than RESET_PLL: same action as lock loss, without any counter increment. In RESET_PLL it restarts the pulse-width count.
- Simultaneous lock loss and restart_req in RUN: count the lock loss once; the action is identical.
- Counter saturation: relock_count and timeout_count saturate at 255. fault clears only on rst_n.
- Wrap-around: internal cycle counters are sized with $clog2 of the largest parameter plus 1 and never wrap.
- Reset mid-sequence: asserting rst_n forces the reset values immediately (asynchronously), whatever the state.

Decomposition:
- Package tmds_pll_pkg: state enum (RESET_PLL, WAIT_LOCK, RELEASE_SER, RUN) and the count width constant.
- One sub-module, sync_2ff (single-bit 2-flop synchroniser with async active-low reset to 0), reused for pll_lock.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_GAP_CYCLES=2, MAX_RETRIES=2.
1. Power-up: release rst_n at cycle 0, pll_lock=1 from cycle 0.
   - pll_reset high for cycles 0-3, low from cycle 4.
   - ser_rst_n rises 8 stable cycles after lock_s is valid in WAIT_LOCK; pix_rst_n and ready rise 2 cycles later.
   - relock_count=0.
2. Lock glitch: pll_lock dropped for 1 cycle after 5 stable cycles in WAIT_LOCK -> stable counter restarts; ser_rst_n delayed by the full 8 cycles after recovery; pll_reset stays 0.
3. Lock loss in RUN: drop pll_lock -> 3 cycles after the pin falls, pll_reset=1, ser_rst_n=0, pix_rst_n=0, ready=0, relock_count=1; on relock the full sequence repeats.
4. Timeout: pll_lock held 0 -> a 4-cycle pll_reset pulse every 32+4 cycles; timeout_count increments to 1, then 2; fault=1 after the second timeout and stays 1 after lock succeeds.
5. restart_req pulsed in RUN together with lock loss -> relock_count increments by exactly 1; restart_req alone -> no count change, full resequence.
6. rst_n asserted mid-RELEASE_SER -> outputs return to reset values within the same cycle (asynchronous); counts cleared to 0.
